// File: rtl/xy_router_vc.sv
// xy_router_vc: 5-port XY mesh router, per-input FIFO, per-output round-robin arbiter and output register.
// Latency: 2 cycles from input accept to out_valid when uncontended; 1 flit/cycle per output.
// Backpressure: out_ready low holds the output register, the granted FIFO fills, and in_ready (=!full) drops.
// Optional per-output forward counters: define XY_ROUTER_VC_STATS_EN.

module xy_router_vc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module xy_router_vc #(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      router_x,
  input  logic [COORD_W-1:0]      router_y,
  input  logic [5*DATA_WIDTH-1:0] in_data,
  input  logic [4:0]              in_valid,
  output logic [4:0]              in_ready,
  output logic [5*DATA_WIDTH-1:0] out_data,
  output logic [4:0]              out_valid,
  input  logic [4:0]              out_ready
`ifdef XY_ROUTER_VC_STATS_EN
  ,
  output logic [5*32-1:0]         stat_fwd_count
`endif
);
  localparam int NP = 5;
  localparam logic [2:0] P_L = 3'd0, P_N = 3'd1, P_S = 3'd2, P_E = 3'd3, P_W = 3'd4;

  logic [NP-1:0]         fifo_full;
  logic [NP-1:0]         fifo_empty;
  logic [NP-1:0]         pop;
  logic [DATA_WIDTH-1:0] head       [NP];
  logic [2:0]            route      [NP];
  logic [NP-1:0]         req        [NP];
  logic [2:0]            last_grant [NP];
  logic [NP-1:0]         gnt_vld;
  logic [2:0]            gnt_idx    [NP];

  assign in_ready = ~fifo_full;

  for (genvar p = 0; p < NP; p++) begin : g_in
    xy_router_vc_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (in_valid[p] & ~fifo_full[p]),
      .wr_dat (in_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en  (pop[p]),
      .rd_dat (head[p]),
      .full   (fifo_full[p]),
      .empty  (fifo_empty[p])
    );
  end

  // Dimension-ordered routing: resolve X fully before Y.
  always_comb begin
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    for (int p = 0; p < NP; p++) begin
      dx = head[p][2*COORD_W-1 -: COORD_W];
      dy = head[p][COORD_W-1:0];
      if (dx > router_x)      route[p] = P_E;
      else if (dx < router_x) route[p] = P_W;
      else if (dy > router_y) route[p] = P_S;
      else if (dy < router_y) route[p] = P_N;
      else                    route[p] = P_L;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      for (int p = 0; p < NP; p++) begin
        req[o][p] = !fifo_empty[p] && (route[p] == 3'(o));
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NP; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = 3'd0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int k = 1; k <= NP; k++) begin
          idx = int'(last_grant[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!gnt_vld[o] && req[o][idx]) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = 3'(idx);
          end
        end
      end
    end
  end

  // Each head targets one output, so at most one grant lands on any FIFO.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      for (int o = 0; o < NP; o++) last_grant[o] <= 3'd4;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (gnt_vld[o]) begin
          out_data[o*DATA_WIDTH +: DATA_WIDTH] <= head[gnt_idx[o]];
          out_valid[o]  <= 1'b1;
          last_grant[o] <= gnt_idx[o];
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

`ifdef XY_ROUTER_VC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_count <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o])
          stat_fwd_count[o*32 +: 32] <= stat_fwd_count[o*32 +: 32] + 32'd1;
      end
    end
  end
`endif
endmodule
